jump_scheduler: RTL
===================

// Module: jump_scheduler
// PURPOSE
//  Sits between keyboard and the character/blocks datapath. It turns key_code
//  presses into queued jump requests and issues them one at a time as 1-clk
//  jump_left/jump_right pulses. Each jump must land (or fail) before the next
//  jump is issued. A fail or land timeout flushes the queue.
// PARAMETERS
//  FIFO_DEPTH       4     queued jumps; power of 2, >=2
//  LAND_TIMEOUT_MS  2000  ms ticks in AIR before a forced flush; 1..65535
//  KEY_LEFT         2'b01 key_code value meaning left jump
//  KEY_RIGHT        2'b10 key_code value meaning right jump
// PORTS
//  clk          in   1   40 MHz system clock
//  rst          in   1   asynchronous, active-low reset
//  module_en    in   1   FSM enable; low = clear queue, force IDLE
//  key          in   2   keyboard key_code, level, 2'b00 = none
//  one_ms_tick  in   1   1-clk pulse every ms
//  landed       in   1   character landing pulse
//  jump_fail    in   1   blocks miss flag, level
//  jump_left    out  1   1-clk pulse: start left jump
//  jump_right   out  1   1-clk pulse: start right jump
//  busy         out  1   high in FIRE/AIR/FLUSH
//  queue_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued
//  overflow     out  1   1-clk pulse: request dropped, queue full
//  timeout      out  1   1-clk pulse: AIR exceeded LAND_TIMEOUT_MS
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, queue empty, key_q=2'b00, timer 0.
//  Request detect:
//   - Condition: key is KEY_LEFT or KEY_RIGHT, and key != key_q.
//   - key_q is registered every clk, regardless of module_en.
//   - A held key gives exactly one request.
//   - 2'b11 and 2'b00 are never requests.
//  Queue: 1-bit entries (0=left, 1=right), circular pointers, wrap at FIFO_DEPTH.
//   - Push on request when module_en=1, state!=FLUSH and count<FIFO_DEPTH.
//   - Push while full: request dropped, overflow=1 next clk, count unchanged.
//   - Push and pop in the same clk: count unchanged, both performed.
//  FSM states: IDLE, FIRE, AIR, FLUSH.
//   - IDLE -> FIRE when module_en and count!=0. Pop the head at the same edge.
//   - FIRE (1 clk): drive jump_left or jump_right for the popped entry
//     (registered). Clear timer. Go to AIR.
//   - AIR: count one_ms_tick in a 16-bit timer. Exits, highest priority first:
//     (a) jump_fail=1 -> FLUSH.
//     (b) landed=1 -> IDLE.
//     (c) timer reaches LAND_TIMEOUT_MS -> timeout=1 for 1 clk, then FLUSH.
//     landed and jump_fail in the same clk -> FLUSH.
//   - FLUSH (1 clk): pointers and count cleared, requests ignored -> IDLE.
//  Latency: key changes at edge k with queue empty, IDLE, enabled:
//   - count=1 after edge k; FIRE after edge k+1.
//   - jump_* high in the clk after edge k+2.
//  Back-to-back: landed at edge m with count>0:
//   - IDLE at m, FIRE at m+1, next jump_* pulse after edge m+2.
//  module_en low (any state, mid-jump included), effective next edge:
//   - state IDLE, queue cleared, timer 0, jump_* 0, no timeout.
//   - Requests while disabled are discarded.
//  jump_left and jump_right are never high together. Each pulses at most once
//   per FIRE.
//  queue_count width holds FIFO_DEPTH exactly; the pointers never alias full
//   with empty.
//  Async reset mid-jump: all outputs drop immediately; no pulse after release.
// TESTING
//  1 Reset, en=1, key 00->01 held 10 clk -> one jump_left pulse 3 clk after
//    change; queue_count 1 then 0.
//  2 In AIR, press R,L,R,L,R (queue 4) -> 5th press gives overflow pulse,
//    queue_count=4. Each landed issues the next jump in order R,L,R,L.
//  3 AIR with queue 2, jump_fail=1 -> FLUSH, queue_count=0, no further
//    jump_* pulses.
//  4 LAND_TIMEOUT_MS=5, no landed -> timeout pulse on 5th ms tick,
//    queue flushed, state IDLE.
//  5 landed and jump_fail same clk with queue 1 -> flush, no jump issued.
//    Separately, push+pop same clk -> count unchanged.
//  6 module_en low during AIR with queue 3 -> next clk count=0, busy=0.
//    Keys while disabled -> no jumps after re-enable.

Source files
------------

// File: rtl/jump_scheduler.sv
// Keyboard-to-jump scheduler: queues left/right key presses and issues them as
// single-cycle jump pulses, one in flight at a time, with fail/timeout flush.
module jump_scheduler #(
  parameter int         FIFO_DEPTH      = 4,
  parameter int         LAND_TIMEOUT_MS = 2000,
  parameter logic [1:0] KEY_LEFT        = 2'b01,
  parameter logic [1:0] KEY_RIGHT       = 2'b10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          module_en,
  input  logic [1:0]                    key,
  input  logic                          one_ms_tick,
  input  logic                          landed,
  input  logic                          jump_fail,
  output logic                          jump_left,
  output logic                          jump_right,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   queue_count,
  output logic                          overflow,
  output logic                          timeout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIRE  = 2'd1;
  localparam logic [1:0] ST_AIR   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [1:0]            key_q_reg;
  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg, count_next;
  logic [FIFO_DEPTH-1:0] fifo_mem_reg;
  logic [FIFO_DEPTH-1:0] wr_en;
  logic                  dir_reg;
  logic                  jump_left_reg, jump_right_reg;
  logic                  overflow_reg, timeout_reg;
  logic [15:0]           timer_reg;

  logic request, accept_window, full, push, drop, pop, push_dir;
  logic timer_hit, clear_queue, timeout_next;

  // A request is an edge into a direction key; holding it produces nothing more.
  assign request       = ((key == KEY_LEFT) || (key == KEY_RIGHT)) && (key != key_q_reg);
  assign push_dir      = (key == KEY_RIGHT);
  assign accept_window = module_en && (state_reg != ST_FLUSH);
  assign full          = (count_reg == CW'(FIFO_DEPTH));
  assign push          = request && accept_window && !full;
  assign drop          = request && accept_window && full;
  assign pop           = module_en && (state_reg == ST_IDLE) && (count_reg != '0);
  assign timer_hit     = one_ms_tick &&
                         (({1'b0, timer_reg} + 17'd1) >= 17'(LAND_TIMEOUT_MS));

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
  end

  always_comb begin
    state_next   = state_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE:  if (pop) state_next = ST_FIRE;
      ST_FIRE:  state_next = ST_AIR;
      ST_AIR: begin
        if (jump_fail) begin
          state_next = ST_FLUSH;
        end else if (landed) begin
          state_next = ST_IDLE;
        end else if (timer_hit) begin
          state_next   = ST_FLUSH;
          timeout_next = 1'b1;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
    if (!module_en) begin
      state_next   = ST_IDLE;
      timeout_next = 1'b0;
    end
  end

  // The queue empties on the edge entering FLUSH, so a press racing that edge is lost too.
  assign clear_queue = !module_en || (state_reg == ST_FLUSH) ||
                       ((state_reg == ST_AIR) && (state_next == ST_FLUSH));

  always_comb begin
    count_next = count_reg + CW'(push) - CW'(pop);
    if (clear_queue) count_next = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      key_q_reg      <= 2'b00;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      fifo_mem_reg   <= '0;
      dir_reg        <= 1'b0;
      jump_left_reg  <= 1'b0;
      jump_right_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      timeout_reg    <= 1'b0;
      timer_reg      <= '0;
    end else begin
      key_q_reg      <= key;
      state_reg      <= state_next;
      count_reg      <= count_next;
      overflow_reg   <= drop;
      timeout_reg    <= timeout_next;
      jump_left_reg  <= module_en && (state_reg == ST_FIRE) && !dir_reg;
      jump_right_reg <= module_en && (state_reg == ST_FIRE) && dir_reg;

      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (wr_en[i]) fifo_mem_reg[i] <= push_dir;
      end

      if (clear_queue) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
          dir_reg    <= fifo_mem_reg[rd_ptr_reg];
        end
      end

      if (!module_en || (state_reg == ST_FIRE)) begin
        timer_reg <= '0;
      end else if ((state_reg == ST_AIR) && one_ms_tick) begin
        timer_reg <= timer_reg + 16'd1;
      end
    end
  end

  assign jump_left   = jump_left_reg;
  assign jump_right  = jump_right_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign queue_count = count_reg;
  assign overflow    = overflow_reg;
  assign timeout     = timeout_reg;

endmodule
